// File: rtl/uart_coord_packer.sv
// uart_coord_packer
// Frames ball-detection results into fixed 8-byte packets for the UART byte
// transmitter: AA, x[15:8], x[7:0], y[15:8], y[7:0], {7'b0,found}, checksum, 55.
// The transmitter has no ready output and reads its data input for the whole
// frame. Bytes are therefore paced by a fixed slot of GAP_BITS bit periods,
// and tx_data stays constant between start pulses.
//
// Ports:
//   sys_clk      in   system clock
//   sys_rst_n    in   asynchronous active-low reset
//   coord_valid  in   1-cycle strobe qualifying ball_x/ball_y/ball_found
//   ball_x       in   ball centre column (COORD_W bits, zero-extended to 16)
//   ball_y       in   ball centre row    (COORD_W bits, zero-extended to 16)
//   ball_found   in   1 = ball detected in the frame
//   tx_data      out  byte to the transmitter, held for the whole byte slot
//   tx_flag      out  1-cycle start pulse to the transmitter
//   busy         out  packet in progress
//   ovr_cnt      out  saturating count of pending samples overwritten unsent
module uart_coord_packer #(
    parameter int          UART_BPS = 9600,
    parameter int          CLK_FREQ = 50_000_000,
    parameter int          COORD_W  = 12,
    parameter int          GAP_BITS = 11,
    parameter logic [7:0]  HEADER   = 8'hAA,
    parameter logic [7:0]  TAIL     = 8'h55
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               coord_valid,
    input  logic [COORD_W-1:0] ball_x,
    input  logic [COORD_W-1:0] ball_y,
    input  logic               ball_found,
    output logic [7:0]         tx_data,
    output logic               tx_flag,
    output logic               busy,
    output logic [7:0]         ovr_cnt
);

    localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int GAP_MAX      = BAUD_CNT_MAX * GAP_BITS;
    localparam int GAP_W        = ($clog2(GAP_MAX) > 20) ? $clog2(GAP_MAX) : 20;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_MAX - 1);

    // Launching a byte is folded into the transition that enters or stays in
    // WAIT_GAP, so the start pulse appears in the cycle right after
    // coord_valid (or right after the previous slot's terminal count).
    typedef enum logic [0:0] {
        IDLE,
        WAIT_GAP
    } state_t;

    state_t           state;
    logic [2:0]       idx;
    logic [GAP_W-1:0] gap_cnt;

    logic [15:0]      pkt_x;
    logic [15:0]      pkt_y;
    logic             pkt_found;

    logic [15:0]      pend_x;
    logic [15:0]      pend_y;
    logic             pend_found;
    logic             pending;

    logic [15:0]      in_x;
    logic [15:0]      in_y;
    logic [2:0]       idx_next;
    logic [7:0]       checksum;
    logic [7:0]       next_byte;
    logic             slot_end;
    logic             last_slot_end;

    assign in_x     = 16'(ball_x);
    assign in_y     = 16'(ball_y);
    assign idx_next = idx + 3'd1;

    // Eight-bit sum wraps naturally, giving the mod-256 checksum.
    assign checksum = pkt_x[15:8] + pkt_x[7:0] + pkt_y[15:8] + pkt_y[7:0]
                    + {7'b0, pkt_found};

    assign slot_end      = (gap_cnt == GAP_LAST);
    assign last_slot_end = slot_end && (idx == 3'd7);

    always_comb begin
        next_byte = TAIL;
        case (idx_next)
            3'd0:    next_byte = HEADER;
            3'd1:    next_byte = pkt_x[15:8];
            3'd2:    next_byte = pkt_x[7:0];
            3'd3:    next_byte = pkt_y[15:8];
            3'd4:    next_byte = pkt_y[7:0];
            3'd5:    next_byte = {7'b0, pkt_found};
            3'd6:    next_byte = checksum;
            default: next_byte = TAIL;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            idx        <= 3'd0;
            gap_cnt    <= '0;
            pkt_x      <= 16'h0000;
            pkt_y      <= 16'h0000;
            pkt_found  <= 1'b0;
            pend_x     <= 16'h0000;
            pend_y     <= 16'h0000;
            pend_found <= 1'b0;
            pending    <= 1'b0;
            tx_data    <= 8'h00;
            tx_flag    <= 1'b0;
            busy       <= 1'b0;
            ovr_cnt    <= 8'h00;
        end else begin
            tx_flag <= 1'b0;
            case (state)
                IDLE: begin
                    if (coord_valid) begin
                        pkt_x     <= in_x;
                        pkt_y     <= in_y;
                        pkt_found <= ball_found;
                        idx       <= 3'd0;
                        gap_cnt   <= '0;
                        tx_data   <= HEADER;
                        tx_flag   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= WAIT_GAP;
                    end
                end

                WAIT_GAP: begin
                    if (!slot_end) begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end else begin
                        gap_cnt <= '0;
                        if (idx != 3'd7) begin
                            idx     <= idx_next;
                            tx_data <= next_byte;
                            tx_flag <= 1'b1;
                        end else if (pending || coord_valid) begin
                            // A strobe landing on the final terminal count is
                            // newer than anything buffered, so it wins.
                            if (coord_valid) begin
                                pkt_x     <= in_x;
                                pkt_y     <= in_y;
                                pkt_found <= ball_found;
                            end else begin
                                pkt_x     <= pend_x;
                                pkt_y     <= pend_y;
                                pkt_found <= pend_found;
                            end
                            pending <= 1'b0;
                            idx     <= 3'd0;
                            tx_data <= HEADER;
                            tx_flag <= 1'b1;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end

                    if (coord_valid && !last_slot_end) begin
                        pend_x     <= in_x;
                        pend_y     <= in_y;
                        pend_found <= ball_found;
                        pending    <= 1'b1;
                    end

                    // Any strobe that finds an unsent sample discards it.
                    if (coord_valid && pending && (ovr_cnt != 8'hFF)) begin
                        ovr_cnt <= ovr_cnt + 8'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
